commit_lockstep_checker: RTL and testbench

- Sits between the two harness instances (primary and variant) and the testbench pass/fail logic.
- Buffers each instance's retirement stream in its own FIFO and pairs the streams commit-for-commit.
- Compares PC, instruction and writeback data for each pair.
- Raises a sticky failure with a cause code, which the testbench turns into the "*** FAILED ***" report.

---
 rtl/commit_lockstep_checker.sv | 87 ++++++++
 tb/tb_commit_lockstep_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_lockstep_checker.sv
// commit_lockstep_checker: pairs two retirement streams through per-stream FIFOs and flags
// the first mismatch, FIFO overflow or excessive skew as a sticky failure.
module commit_lockstep_checker #(
  parameter int DEPTH = 16,
  parameter int SKEW_LIMIT = 1024,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             check_en,
  input  logic             a_valid,
  input  logic [63:0]      a_pc,
  input  logic [31:0]      a_inst,
  input  logic [63:0]      a_wdata,
  input  logic             b_valid,
  input  logic [63:0]      b_pc,
  input  logic [31:0]      b_inst,
  input  logic [63:0]      b_wdata,
  output logic             failure,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] commit_count,
  output logic [63:0]      bad_pc_a,
  output logic [63:0]      bad_pc_b
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SKEW_LIMIT + 1);
  typedef enum logic {RUN, FAIL} state_t;
  state_t state, state_n;
  logic [159:0] din [2];
  logic [159:0] head [2];
  logic [1:0] vld, ne, full, pop, push, ovf;
  logic run, cmp, mism, skew_inc, skew_hit;
  logic [1:0] code_n;
  logic [SW-1:0] skew;
  assign din[0] = {a_pc, a_inst, a_wdata};
  assign din[1] = {b_pc, b_inst, b_wdata};
  assign vld = {b_valid, a_valid};
  // Stream 0 is the primary, stream 1 the variant; pointers carry a wrap bit.
  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [159:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign ne[s] = wp != rp;
    assign full[s] = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign head[s] = mem[rp[AW-1:0]];
    assign push[s] = vld[s] & (~full[s] | pop[s]);
    assign ovf[s] = vld[s] & full[s] & ~pop[s];
    always_ff @(posedge clock)
      if (push[s]) mem[wp[AW-1:0]] <= din[s];
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push[s]) wp <= wp + 1'b1;
        if (pop[s]) rp <= rp + 1'b1;
      end
  end
  assign run = state == RUN;
  assign cmp = run & check_en & (&ne);
  assign pop = run ? (check_en ? {2{cmp}} : ne) : 2'b00;
  assign mism = cmp & (head[0] != head[1]);
  assign skew_inc = run & check_en & (^ne);
  assign skew_hit = skew_inc & (skew == SW'(SKEW_LIMIT - 1));
  assign failure = state == FAIL;
  always_comb begin
    code_n = mism ? 2'd1 : (|ovf) ? 2'd2 : skew_hit ? 2'd3 : 2'd0;
    state_n = (run && code_n != 2'd0) ? FAIL : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= RUN;
      fail_code <= 2'd0;
      skew <= '0;
      commit_count <= '0;
      bad_pc_a <= '0;
      bad_pc_b <= '0;
    end else begin
      state <= state_n;
      if (run) fail_code <= code_n;
      skew <= skew_inc ? skew + 1'b1 : run ? '0 : skew;
      if (cmp && !mism && !(&commit_count)) commit_count <= commit_count + 1'b1;
      if (mism) begin
        bad_pc_a <= head[0][159:96];
        bad_pc_b <= head[1][159:96];
      end
    end
endmodule

// File: tb/tb_commit_lockstep_checker.sv
// tb_commit_lockstep_checker: directed scenarios on two checker instances (skew limit 8 and 1024)
// with a queue of expected commit counts consumed as the count advances.
module tb_commit_lockstep_checker;
  logic clock = 1'b0;
  logic reset, check_en;
  logic a_valid, b_valid;
  logic [63:0] a_pc, a_wdata, b_pc, b_wdata;
  logic [31:0] a_inst, b_inst;
  logic f0, f1;
  logic [1:0] c0, c1;
  logic [63:0] cnt0, cnt1, pa0, pb0, pa1, pb1;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];
  logic [63:0] exp_cnt;
  logic [63:0] last_cnt = '0;

  always #5 clock = ~clock;

  commit_lockstep_checker #(.DEPTH(16), .SKEW_LIMIT(8), .CNT_W(64)) d0 (
    .clock(clock), .reset(reset), .check_en(check_en),
    .a_valid(a_valid), .a_pc(a_pc), .a_inst(a_inst), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_pc(b_pc), .b_inst(b_inst), .b_wdata(b_wdata),
    .failure(f0), .fail_code(c0), .commit_count(cnt0), .bad_pc_a(pa0), .bad_pc_b(pb0));

  commit_lockstep_checker #(.DEPTH(16), .SKEW_LIMIT(1024), .CNT_W(64)) d1 (
    .clock(clock), .reset(reset), .check_en(check_en),
    .a_valid(a_valid), .a_pc(a_pc), .a_inst(a_inst), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_pc(b_pc), .b_inst(b_inst), .b_wdata(b_wdata),
    .failure(f1), .fail_code(c1), .commit_count(cnt1), .bad_pc_a(pa1), .bad_pc_b(pb1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] wd);
    a_valid = v; a_pc = pc; a_inst = inst; a_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] wd);
    b_valid = v; b_pc = pc; b_inst = inst; b_wdata = wd;
  endtask

  task automatic do_reset();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic expect_commit();
    exp_cnt++;
    exp_q.push_back(exp_cnt);
  endtask

  // Scoreboard: each change of the count must match the next queued expectation.
  always @(negedge clock) begin
    if (!reset) last_cnt = '0;
    else if (cnt1 != last_cnt) begin
      if (exp_q.size() == 0) chk("sb_unexpected", cnt1, last_cnt);
      else chk("sb_count", cnt1, exp_q.pop_front());
      last_cnt = cnt1;
    end
  end

  initial begin
    logic [63:0] pc, wd;
    logic [31:0] inst;
    reset = 1'b0;
    check_en = 1'b1;
    exp_cnt = '0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    #1;
    chk("rst_failure", f1, 0);
    chk("rst_code", c1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_pca", pa1, 0);
    chk("rst_pcb", pb1, 0);
    chk("rst_failure0", f0, 0);
    step();
    step();
    reset = 1'b1;

    for (int i = 0; i < 100; i++) begin
      pc = 64'h8000_0000 + 64'(4 * i);
      inst = $urandom;
      wd = {$urandom, $urandom};
      set_a(1, pc, inst, wd);
      set_b(1, pc, inst, wd);
      expect_commit();
      step();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (4) step();
    chk("match_count", cnt1, 100);
    chk("match_count0", cnt0, 100);
    chk("match_failure", f1, 0);
    chk("match_failure0", f0, 0);
    chk("match_sb_drained", 64'(exp_q.size()), 0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i < 10) set_a(1, 64'h8000_1000 + 64'(4 * i), 32'h13 + 32'(i), 64'(3 * i));
      else set_a(0, 0, 0, 0);
      if (i >= 5) begin
        set_b(1, 64'h8000_1000 + 64'(4 * (i - 5)), 32'h13 + 32'(i - 5), 64'(3 * (i - 5)));
        expect_commit();
      end
      step();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (4) step();
    chk("offset_count", cnt1, 10);
    chk("offset_failure", f1, 0);
    chk("offset_failure0", f0, 0);
    chk("offset_sb_drained", 64'(exp_q.size()), 0);

    do_reset();
    check_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_a(1, 64'h9000_0000 + 64'(i), 32'h1, 64'h0);
      step();
    end
    set_a(0, 0, 0, 0);
    step();
    check_en = 1'b1;
    repeat (12) step();
    chk("drain_failure0", f0, 0);
    chk("drain_failure", f1, 0);
    chk("drain_count", cnt1, 0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_a(1, 64'hA000_0000 + 64'(4 * i), 32'h33, 64'(i));
      step();
      if (i == 15) chk("ovf_before_failure", f1, 0);
    end
    set_a(0, 0, 0, 0);
    chk("ovf_failure", f1, 1);
    chk("ovf_code", c1, 2);
    chk("ovf_skew_failure0", f0, 1);
    chk("ovf_skew_code0", c0, 3);
    repeat (3) step();
    chk("ovf_code_held", c1, 2);

    do_reset();
    set_a(1, 64'hB000_0000, 32'h13, 64'h0);
    step();
    set_a(0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 7) chk("skew_before_limit", f0, 0);
    end
    chk("skew_failure", f0, 1);
    chk("skew_code", c0, 3);
    chk("skew_far_limit", f1, 0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      pc = 64'h8000_0000 + 64'(4 * i);
      inst = 32'h0000_0093 + 32'(i);
      wd = 64'h100 + 64'(i);
      if (i == 6) begin
        set_a(1, pc, inst, 64'h1);
        set_b(1, pc, inst, 64'h2);
      end else begin
        set_a(1, pc, inst, wd);
        set_b(1, pc, inst, wd);
        if (i < 6) expect_commit();
      end
      step();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (4) step();
    chk("mism_failure", f1, 1);
    chk("mism_code", c1, 1);
    chk("mism_pca", pa1, 64'h8000_0018);
    chk("mism_pcb", pb1, 64'h8000_0018);
    chk("mism_count", cnt1, 6);
    chk("mism_code0", c0, 1);
    chk("mism_sb_drained", 64'(exp_q.size()), 0);

    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_failure", f1, 0);
    chk("async_code", c1, 0);
    chk("async_count", cnt1, 0);
    chk("async_pca", pa1, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      set_a(1, 64'hC000_0000 + 64'(4 * i), 32'h13, 64'(i));
      set_b(1, 64'hC000_0000 + 64'(4 * i), 32'h13, 64'(i));
      expect_commit();
      step();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (4) step();
    chk("post_reset_count", cnt1, 3);
    chk("post_reset_failure", f1, 0);
    chk("post_reset_sb_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
